// File: rtl/pulse_train_gen_pkg.sv
// Shared types for the key-press pulse train generator.
// Holds the FSM state encoding and key line level constants.
package pulse_gen_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        B_PRESS = 3'd1,
        PRESS   = 3'd2,
        B_REL   = 3'd3,
        GAP     = 3'd4,
        FIN     = 3'd5
    } state_e;

    localparam logic KEY_PRESSED  = 1'b1;
    localparam logic KEY_RELEASED = 1'b0;

endpackage

// File: rtl/pulse_train_gen_if.sv
// Request/status bundle between a train requester and the generator.
// The generator side uses the slave modport.
interface pulse_train_gen_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic [CNT_W-1:0] count;
    logic             bounce_en;
    logic             key_out;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] sent;

    modport master (
        output start, count, bounce_en,
        input  key_out, busy, done, sent
    );

    modport slave (
        input  start, count, bounce_en,
        output key_out, busy, done, sent
    );
endinterface

// File: rtl/pulse_train_gen_cyc_timer.sv
// Reloadable down-counter timing each press, gap and bounce phase.
// expire is high while the count sits at zero.
module cyc_timer #(
    parameter int TIMER_W = 20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_val,
    output logic               expire
);

    logic [TIMER_W-1:0] cnt_q;
    logic [TIMER_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = (cnt_q == '0);

endmodule

// File: rtl/pulse_train_gen.sv
// Emits a programmable train of key presses with optional contact bounce.
// All outputs are registered so key_out never glitches combinationally.
module pulse_train_gen
    import pulse_gen_pkg::*;
#(
    parameter int CNT_W      = 8,
    parameter int TIMER_W    = 20,
    parameter int HIGH_CYC   = 240000,
    parameter int LOW_CYC    = 240000,
    parameter int BOUNCE_N   = 3,
    parameter int BOUNCE_CYC = 1200
) (
    input  logic             clk,
    input  logic             rst,
    pulse_train_gen_if.slave bus
);

    localparam int TOG_W = $clog2(2 * BOUNCE_N + 1);

    localparam logic [TIMER_W-1:0] HIGH_LD = TIMER_W'(HIGH_CYC - 1);
    localparam logic [TIMER_W-1:0] LOW_LD  = TIMER_W'(LOW_CYC - 1);
    localparam logic [TIMER_W-1:0] BNC_LD  = TIMER_W'(BOUNCE_CYC - 1);
    localparam logic [TOG_W-1:0]   TOG_END = TOG_W'(2 * BOUNCE_N - 1);

    state_e           state_q, state_d;
    logic             key_q, key_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] sent_q, sent_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             bounce_q, bounce_d;
    logic [TOG_W-1:0] tog_q, tog_d;

    logic               tmr_load;
    logic [TIMER_W-1:0] tmr_val;
    logic               tmr_exp;

    cyc_timer #(
        .TIMER_W (TIMER_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expire   (tmr_exp)
    );

    always_comb begin
        state_d  = state_q;
        key_d    = key_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        sent_d   = sent_q;
        count_d  = count_q;
        bounce_d = bounce_q;
        tog_d    = tog_q;
        tmr_load = 1'b0;
        tmr_val  = '0;

        unique case (state_q)
            IDLE: begin
                key_d  = KEY_RELEASED;
                busy_d = 1'b0;
                if (bus.start) begin
                    count_d  = bus.count;
                    bounce_d = bus.bounce_en;
                    sent_d   = '0;
                    tog_d    = '0;
                    if (bus.count == '0) begin
                        state_d = FIN;
                        done_d  = 1'b1;
                    end else begin
                        busy_d   = 1'b1;
                        key_d    = KEY_PRESSED;
                        tmr_load = 1'b1;
                        if (bus.bounce_en) begin
                            state_d = B_PRESS;
                            tmr_val = BNC_LD;
                        end else begin
                            state_d = PRESS;
                            tmr_val = HIGH_LD;
                        end
                    end
                end
            end
            B_PRESS: begin
                if (tmr_exp) begin
                    tmr_load = 1'b1;
                    // last toggle lands the line on the stable press level
                    if (tog_q == TOG_END) begin
                        state_d = PRESS;
                        key_d   = KEY_PRESSED;
                        tog_d   = '0;
                        tmr_val = HIGH_LD;
                    end else begin
                        key_d   = ~key_q;
                        tog_d   = tog_q + 1'b1;
                        tmr_val = BNC_LD;
                    end
                end
            end
            PRESS: begin
                if (tmr_exp) begin
                    sent_d   = sent_q + 1'b1;
                    key_d    = KEY_RELEASED;
                    tog_d    = '0;
                    tmr_load = 1'b1;
                    if (bounce_q) begin
                        state_d = B_REL;
                        tmr_val = BNC_LD;
                    end else begin
                        state_d = GAP;
                        tmr_val = LOW_LD;
                    end
                end
            end
            B_REL: begin
                if (tmr_exp) begin
                    tmr_load = 1'b1;
                    if (tog_q == TOG_END) begin
                        state_d = GAP;
                        key_d   = KEY_RELEASED;
                        tog_d   = '0;
                        tmr_val = LOW_LD;
                    end else begin
                        key_d   = ~key_q;
                        tog_d   = tog_q + 1'b1;
                        tmr_val = BNC_LD;
                    end
                end
            end
            GAP: begin
                if (tmr_exp) begin
                    if (sent_q == count_q) begin
                        state_d = FIN;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        key_d    = KEY_PRESSED;
                        tmr_load = 1'b1;
                        if (bounce_q) begin
                            state_d = B_PRESS;
                            tmr_val = BNC_LD;
                        end else begin
                            state_d = PRESS;
                            tmr_val = HIGH_LD;
                        end
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                key_d   = KEY_RELEASED;
            end
            default: begin
                state_d = IDLE;
                key_d   = KEY_RELEASED;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            key_q    <= KEY_RELEASED;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sent_q   <= '0;
            count_q  <= '0;
            bounce_q <= 1'b0;
            tog_q    <= '0;
        end else begin
            state_q  <= state_d;
            key_q    <= key_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            sent_q   <= sent_d;
            count_q  <= count_d;
            bounce_q <= bounce_d;
            tog_q    <= tog_d;
        end
    end

    assign bus.key_out = key_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.sent    = sent_q;

endmodule

// File: tb/tb_pulse_train_gen.sv
// Scoreboard bench for pulse_train_gen with short phase timings.
// Includes a small debounce + press counter fed from key_out.
module tb_pulse_train_gen;
    import pulse_gen_pkg::*;

    localparam int CNT_W      = 8;
    localparam int TIMER_W    = 20;
    localparam int HIGH_CYC   = 4;
    localparam int LOW_CYC    = 3;
    localparam int BOUNCE_N   = 2;
    localparam int BOUNCE_CYC = 1;
    localparam int DEB        = 2;

    typedef struct {
        logic             key;
        logic             busy;
        logic             done;
        logic [CNT_W-1:0] sent;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    logic deb_q     = 1'b0;
    int   deb_cnt   = 0;
    int   press_cnt = 0;
    logic deb_clr   = 1'b0;

    always #5 clk = ~clk;

    pulse_train_gen_if #(.CNT_W(CNT_W)) bus ();

    pulse_train_gen #(
        .CNT_W      (CNT_W),
        .TIMER_W    (TIMER_W),
        .HIGH_CYC   (HIGH_CYC),
        .LOW_CYC    (LOW_CYC),
        .BOUNCE_N   (BOUNCE_N),
        .BOUNCE_CYC (BOUNCE_CYC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // downstream debounce: accept a new level after DEB stable cycles
    always @(posedge clk) begin
        if (bus.key_out != deb_q) begin
            if (deb_cnt == DEB - 1) begin
                deb_q   <= bus.key_out;
                deb_cnt <= 0;
                if (bus.key_out == KEY_PRESSED) press_cnt <= press_cnt + 1;
            end else begin
                deb_cnt <= deb_cnt + 1;
            end
        end else begin
            deb_cnt <= 0;
        end
        if (deb_clr) press_cnt <= 0;
    end

    task automatic check_eq(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic void push_exp(logic k, logic b, logic d, logic [CNT_W-1:0] s);
        exp_t e;
        e.key  = k;
        e.busy = b;
        e.done = d;
        e.sent = s;
        sb.push_back(e);
    endfunction

    function automatic void push_train(int n, bit bnc);
        logic [CNT_W-1:0] s = '0;
        if (n == 0) begin
            push_exp(1'b0, 1'b0, 1'b1, '0);
            return;
        end
        for (int i = 0; i < n; i++) begin
            if (bnc)
                for (int k = 0; k < 2 * BOUNCE_N * BOUNCE_CYC; k++)
                    push_exp(((k / BOUNCE_CYC) % 2) == 0, 1'b1, 1'b0, s);
            for (int k = 0; k < HIGH_CYC; k++)
                push_exp(1'b1, 1'b1, 1'b0, s);
            s++;
            if (bnc)
                for (int k = 0; k < 2 * BOUNCE_N * BOUNCE_CYC; k++)
                    push_exp(((k / BOUNCE_CYC) % 2) == 1, 1'b1, 1'b0, s);
            for (int k = 0; k < LOW_CYC; k++)
                push_exp(1'b0, 1'b1, 1'b0, s);
        end
        push_exp(1'b0, 1'b0, 1'b1, s);
    endfunction

    task automatic run_train(string tag, int n, bit bnc, int glitch_at, int abort_at);
        exp_t e;
        int   idx = 0;
        bit   aborted = 0;
        logic [CNT_W-1:0] last_sent = '0;
        @(negedge clk);
        bus.start     = 1'b1;
        bus.count     = CNT_W'(n);
        bus.bounce_en = bnc;
        push_train(n, bnc);
        @(posedge clk);
        while (sb.size() > 0) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (idx == glitch_at) begin
                bus.start     = 1'b1;
                bus.count     = 8'd9;
                bus.bounce_en = ~bnc;
            end
            e = sb.pop_front();
            last_sent = e.sent;
            check_eq({tag, ".key"},  32'(bus.key_out), 32'(e.key));
            check_eq({tag, ".busy"}, 32'(bus.busy),    32'(e.busy));
            check_eq({tag, ".done"}, 32'(bus.done),    32'(e.done));
            check_eq({tag, ".sent"}, 32'(bus.sent),    32'(e.sent));
            if (idx == abort_at) begin
                #1 rst = 1'b1;
                #1;
                check_eq({tag, ".rst_key"},  32'(bus.key_out), 32'd0);
                check_eq({tag, ".rst_busy"}, 32'(bus.busy),    32'd0);
                check_eq({tag, ".rst_sent"}, 32'(bus.sent),    32'd0);
                sb.delete();
                aborted = 1;
            end
            idx++;
        end
        @(negedge clk);
        bus.start = 1'b0;
        if (aborted) begin
            rst = 1'b0;
            return;
        end
        check_eq({tag, ".post_done"}, 32'(bus.done), 32'd0);
        check_eq({tag, ".post_busy"}, 32'(bus.busy), 32'd0);
        check_eq({tag, ".post_key"},  32'(bus.key_out), 32'd0);
        repeat (2) @(negedge clk);
        check_eq({tag, ".hold_sent"}, 32'(bus.sent), 32'(last_sent));
        check_eq({tag, ".hold_done"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.count     = '0;
        bus.bounce_en = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst.key",  32'(bus.key_out), 32'd0);
        check_eq("rst.busy", 32'(bus.busy),    32'd0);
        check_eq("rst.done", 32'(bus.done),    32'd0);
        check_eq("rst.sent", 32'(bus.sent),    32'd0);
        rst = 1'b0;

        run_train("n3",    3, 1'b0, -1, -1);
        run_train("n0",    0, 1'b0, -1, -1);
        run_train("b1",    1, 1'b1, -1, -1);
        run_train("mid",   2, 1'b0,  3, -1);
        run_train("abort", 2, 1'b0, -1,  8);
        run_train("post",  2, 1'b0, -1, -1);
        run_train("full",  255, 1'b0, -1, -1);

        @(negedge clk);
        deb_clr = 1'b1;
        @(negedge clk);
        deb_clr = 1'b0;
        run_train("loop", 5, 1'b1, -1, -1);
        repeat (4) @(negedge clk);
        check_eq("loop.cnt", 32'(press_cnt), 32'd5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
